// File: rtl/mac_feeder_if.sv
// Operand stream, mac side-channel and result stream of the mac feeder.
// master is the feeder's view; slave is the surrounding datapath's view.
interface mac_feeder_if #(
    parameter int INW  = 16,
    parameter int OUTW = 48
);
    logic                   s_valid;
    logic                   s_ready;
    logic signed [INW-1:0]  s_in0;
    logic signed [INW-1:0]  s_in1;
    logic signed [INW-1:0]  mac_in0;
    logic signed [INW-1:0]  mac_in1;
    logic                   mac_valid_input;
    logic                   mac_clear_acc;
    logic signed [OUTW-1:0] mac_out;
    logic                   m_valid;
    logic                   m_ready;
    logic signed [OUTW-1:0] m_data;

    modport master (
        input  s_valid, s_in0, s_in1, mac_out, m_ready,
        output s_ready, mac_in0, mac_in1, mac_valid_input,
        output mac_clear_acc, m_valid, m_data
    );

    modport slave (
        output s_valid, s_in0, s_in1, mac_out, m_ready,
        input  s_ready, mac_in0, mac_in1, mac_valid_input,
        input  mac_clear_acc, m_valid, m_data
    );
endinterface

// File: rtl/mac_feeder.sv
// Sequencer feeding N operand pairs into the mac per dot product,
// then capturing, clearing and forwarding the accumulated result.
module mac_feeder #(
    parameter int INW  = 16,
    parameter int OUTW = 48,
    parameter int N    = 8
) (
    input logic          clk,
    input logic          reset,
    mac_feeder_if.master bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        CLR,
        ACC,
        WAIT,
        CAPT
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          count, count_n;
    logic signed [INW-1:0]  in0_q, in0_n;
    logic signed [INW-1:0]  in1_q, in1_n;
    logic                   vin_q, vin_n;
    logic                   clr_q, clr_n;
    logic                   mv_q, mv_n;
    logic signed [OUTW-1:0] md_q, md_n;
    logic                   fire;

    assign bus.s_ready         = (state == ACC);
    assign bus.mac_in0         = in0_q;
    assign bus.mac_in1         = in1_q;
    assign bus.mac_valid_input = vin_q;
    assign bus.mac_clear_acc   = clr_q;
    assign bus.m_valid         = mv_q;
    assign bus.m_data          = md_q;

    assign fire = bus.s_valid && (state == ACC);

    always_comb begin
        state_n = state;
        count_n = count;
        in0_n   = in0_q;
        in1_n   = in1_q;
        vin_n   = 1'b0;
        clr_n   = clr_q;
        mv_n    = mv_q;
        md_n    = md_q;
        if (mv_q && bus.m_ready) begin
            mv_n = 1'b0;
        end
        unique case (state)
            CLR: begin
                clr_n   = 1'b0;
                count_n = '0;
                state_n = ACC;
            end
            ACC: begin
                if (fire) begin
                    in0_n   = bus.s_in0;
                    in1_n   = bus.s_in1;
                    vin_n   = 1'b1;
                    count_n = count + CW'(1);
                    if (count == LAST) begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                state_n = CAPT;
            end
            CAPT: begin
                // Reload in the same edge a held result is taken.
                if (!mv_q || bus.m_ready) begin
                    md_n    = bus.mac_out;
                    mv_n    = 1'b1;
                    clr_n   = 1'b1;
                    state_n = CLR;
                end
            end
            default: begin
                state_n = CLR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= CLR;
            count <= '0;
            in0_q <= '0;
            in1_q <= '0;
            vin_q <= 1'b0;
            clr_q <= 1'b1;
            mv_q  <= 1'b0;
            md_q  <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            in0_q <= in0_n;
            in1_q <= in1_n;
            vin_q <= vin_n;
            clr_q <= clr_n;
            mv_q  <= mv_n;
            md_q  <= md_n;
        end
    end
endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural saturating mac
// on a 48-bit instance (main flows) and a 32-bit instance (saturation).
module tb_mac_feeder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   npass = 0;
    int   rd = 0;
    int   vin_cnt = 0;

    logic signed [63:0] got_q[$];
    int                 gt_q[$];

    logic signed [47:0] acc_a = '0;
    logic signed [31:0] acc_b = '0;

    mac_feeder_if #(.INW(16), .OUTW(48)) ia ();
    mac_feeder_if #(.INW(16), .OUTW(32)) ib ();

    mac_feeder #(.INW(16), .OUTW(48), .N(4)) ua (
        .clk  (clk),
        .reset(reset),
        .bus  (ia)
    );

    mac_feeder #(.INW(16), .OUTW(32), .N(4)) ub (
        .clk  (clk),
        .reset(reset),
        .bus  (ib)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint satw(input longint s, input int w);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
    endfunction

    // Reference mac: clear wins, otherwise saturating accumulate.
    always @(posedge clk) begin
        if (ia.mac_clear_acc)
            acc_a <= '0;
        else if (ia.mac_valid_input)
            acc_a <= 48'(satw(longint'(acc_a)
                     + longint'(ia.mac_in0) * longint'(ia.mac_in1), 48));
        if (ib.mac_clear_acc)
            acc_b <= '0;
        else if (ib.mac_valid_input)
            acc_b <= 32'(satw(longint'(acc_b)
                     + longint'(ib.mac_in0) * longint'(ib.mac_in1), 32));
    end

    assign ia.mac_out = acc_a;
    assign ib.mac_out = acc_b;

    always @(negedge clk) begin
        if (ia.m_valid && ia.m_ready) begin
            got_q.push_back(64'(ia.m_data));
            gt_q.push_back(cyc);
        end
        if (ia.mac_valid_input) vin_cnt++;
    end

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int a, input int b);
        int k;
        ia.s_valid = 1'b1;
        ia.s_in0   = 16'(a);
        ia.s_in1   = 16'(b);
        k = 0;
        while (!ia.s_ready && k < 60) begin
            tick();
            k++;
        end
        chk("push_a_ready", 64'(ia.s_ready), 1);
        tick();
        ia.s_valid = 1'b0;
    endtask

    task automatic push_b(input int a, input int b);
        int k;
        ib.s_valid = 1'b1;
        ib.s_in0   = 16'(a);
        ib.s_in1   = 16'(b);
        k = 0;
        while (!ib.s_ready && k < 60) begin
            tick();
            k++;
        end
        chk("push_b_ready", 64'(ib.s_ready), 1);
        tick();
        ib.s_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic signed [63:0] exp);
        for (int k = 0; k < 60 && got_q.size() <= rd; k++) tick();
        chk({tag, "_avail"}, 64'(got_q.size() > rd), 1);
        if (got_q.size() > rd) begin
            chk(tag, got_q[rd], exp);
            rd++;
        end
    endtask

    initial begin
        int base;
        ia.s_valid = 1'b0;
        ia.s_in0   = '0;
        ia.s_in1   = '0;
        ia.m_ready = 1'b0;
        ib.s_valid = 1'b0;
        ib.s_in0   = '0;
        ib.s_in1   = '0;
        ib.m_ready = 1'b0;

        reset = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", 64'(ia.s_ready), 0);
        chk("rst_m_valid", 64'(ia.m_valid), 0);
        chk("rst_m_data", 64'(ia.m_data), 0);
        chk("rst_clear", 64'(ia.mac_clear_acc), 1);
        chk("rst_vin", 64'(ia.mac_valid_input), 0);
        chk("rst_in0", 64'(ia.mac_in0), 0);
        reset = 1'b1;
        tick();
        chk("rel_s_ready", 64'(ia.s_ready), 1);
        chk("rel_clear", 64'(ia.mac_clear_acc), 0);

        // 1: basic dot product and 3-cycle gap
        ia.m_ready = 1'b1;
        push_a(1, 2);
        push_a(3, 4);
        push_a(5, 6);
        push_a(7, 8);
        chk("t1_in0", 64'(ia.mac_in0), 7);
        chk("t1_in1", 64'(ia.mac_in1), 8);
        chk("t1_vin", 64'(ia.mac_valid_input), 1);
        chk("t1_wait_rdy", 64'(ia.s_ready), 0);
        tick();
        chk("t1_capt_rdy", 64'(ia.s_ready), 0);
        chk("t1_capt_mv", 64'(ia.m_valid), 0);
        tick();
        chk("t1_clr_rdy", 64'(ia.s_ready), 0);
        chk("t1_mv", 64'(ia.m_valid), 1);
        chk("t1_md", 64'(ia.m_data), 100);
        chk("t1_clr", 64'(ia.mac_clear_acc), 1);
        tick();
        chk("t1_acc_rdy", 64'(ia.s_ready), 1);
        chk("t1_mv_drop", 64'(ia.m_valid), 0);
        take("t1_res", 100);

        // 2: stall in CAPT, then reload on release
        ia.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_a(-3, 5);
        for (int i = 0; i < 4; i++) push_a(2, -7);
        tick();
        tick();
        tick();
        chk("t2_stall_rdy", 64'(ia.s_ready), 0);
        chk("t2_hold_mv", 64'(ia.m_valid), 1);
        chk("t2_hold_md", 64'(ia.m_data), -60);
        chk("t2_noclear", 64'(ia.mac_clear_acc), 0);
        tick();
        tick();
        chk("t2_hold_md2", 64'(ia.m_data), -60);
        chk("t2_stall_rdy2", 64'(ia.s_ready), 0);
        ia.m_ready = 1'b1;
        tick();
        chk("t2_reload_mv", 64'(ia.m_valid), 1);
        chk("t2_reload_md", 64'(ia.m_data), -56);
        take("t2_res0", -60);
        take("t2_res1", -56);
        tick();
        chk("t2_drain_mv", 64'(ia.m_valid), 0);

        // 3: gappy input stream
        tick();
        base = vin_cnt;
        for (int i = 0; i < 4; i++) begin
            push_a(1, 1);
            tick();
        end
        take("t3_res", 4);
        chk("t3_pulses", 64'(vin_cnt - base), 4);

        // 4: reset mid-vector discards partial sum
        tick();
        push_a(9, 9);
        push_a(9, 9);
        reset = 1'b0;
        tick();
        chk("t4_rst_mv", 64'(ia.m_valid), 0);
        chk("t4_rst_rdy", 64'(ia.s_ready), 0);
        chk("t4_rst_clr", 64'(ia.mac_clear_acc), 1);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push_a(1, 1);
        take("t4_res", 4);

        // 6: back-to-back vectors with no extra bubble
        tick();
        base = rd;
        for (int i = 0; i < 4; i++) push_a(1, 1);
        for (int i = 0; i < 4; i++) push_a(2, 3);
        take("t6_res0", 4);
        take("t6_res1", 24);
        if (gt_q.size() > base + 1)
            chk("t6_gap", 64'(gt_q[base+1] - gt_q[base]), 7);
        else
            chk("t6_gap_avail", 64'(gt_q.size()), 64'(base + 2));

        // 5: saturated result on 32-bit instance
        ib.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_b(32767, 32767);
        tick();
        tick();
        chk("t5_mv", 64'(ib.m_valid), 1);
        chk("t5_md", 64'(ib.m_data), 64'sd2147483647);
        tick();
        chk("t5_drop", 64'(ib.m_valid), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
